// File: rtl/matrix_pkg.sv
// Shared types and default sizes for the 5x5 matrix fetch/writeback blocks.
package matrix_pkg;

    localparam int unsigned N_DIM  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned N_ELEM = N_DIM * N_DIM;
    localparam int unsigned RC_W   = 3;

    typedef logic [RC_W-1:0] rc_t;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCapture,
        StPresent,
        StDone
    } fetch_state_e;

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major element index tracker: linear idx plus 1-based row/col, wrapping after the last element.
module matrix_index_counter #(
    parameter int unsigned N_DIM = matrix_pkg::N_DIM,
    parameter int unsigned IDX_W = $clog2(N_DIM * N_DIM)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_advance,
    output logic [IDX_W-1:0]   o_idx,
    output matrix_pkg::rc_t    o_row,
    output matrix_pkg::rc_t    o_col,
    output logic               o_last
);
    import matrix_pkg::*;

    localparam rc_t              DIM_RC   = rc_t'(N_DIM);
    localparam rc_t              ONE_RC   = rc_t'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIM * N_DIM - 1);

    logic [IDX_W-1:0] r_idx;
    rc_t              r_row;
    rc_t              r_col;
    logic             w_last;

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= '0;
            r_row <= ONE_RC;
            r_col <= ONE_RC;
        end else if (i_clear || (i_advance && w_last)) begin
            r_idx <= '0;
            r_row <= ONE_RC;
            r_col <= ONE_RC;
        end else if (i_advance) begin
            r_idx <= r_idx + 1'b1;
            if (r_col == DIM_RC) begin
                r_col <= ONE_RC;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_idx  = r_idx;
    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_last;

endmodule

// File: rtl/matrix_fetch.sv
// Sweeps the 5x5 matrix store and streams each word with 1-based row/col tags.
// Optional checksum output enabled by defining MATRIX_FETCH_CSUM_EN.
module matrix_fetch #(
    parameter int unsigned DATA_W    = matrix_pkg::DATA_W,
    parameter int unsigned ADDR_W    = matrix_pkg::ADDR_W,
    parameter int unsigned N_DIM     = matrix_pkg::N_DIM,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_el_valid,
    input  logic              i_el_ready,
    output logic [DATA_W-1:0] o_el_data,
    output matrix_pkg::rc_t   o_el_row,
    output matrix_pkg::rc_t   o_el_col,
    output logic              o_el_last
`ifdef MATRIX_FETCH_CSUM_EN
    ,
    output logic [DATA_W-1:0] o_csum
`endif
);
    import matrix_pkg::*;

    localparam int unsigned N_EL  = N_DIM * N_DIM;
    localparam int unsigned IDX_W = $clog2(N_EL);
    localparam int unsigned LAT_W = 2;

    fetch_state_e      r_state;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_rd;
    logic              r_el_valid;
    logic [DATA_W-1:0] r_el_data;

    logic [IDX_W-1:0]  w_idx;
    rc_t               w_row;
    rc_t               w_col;
    logic              w_last;
    logic              w_start_ok;
    logic              w_handshake;

    assign w_start_ok  = (r_state == StIdle) && i_start;
    assign w_handshake = (r_state == StPresent) && i_el_ready;

    matrix_index_counter #(
        .N_DIM (N_DIM),
        .IDX_W (IDX_W)
    ) u_index (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_start_ok),
        .i_advance (w_handshake),
        .o_idx     (w_idx),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_lat_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_el_valid <= 1'b0;
            r_el_data  <= '0;
        end else begin
            r_mem_rd <= 1'b0;
            r_done   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state  <= StIssue;
                        r_busy   <= 1'b1;
                        r_mem_rd <= 1'b1;
                    end
                end
                StIssue: begin
                    // RD_LAT of 1 needs no wait cycles: data is ready in the next cycle
                    if (RD_LAT == 1) begin
                        r_state <= StCapture;
                    end else begin
                        r_state   <= StWait;
                        r_lat_cnt <= '0;
                    end
                end
                StWait: begin
                    if (r_lat_cnt == LAT_W'(RD_LAT - 2)) begin
                        r_state <= StCapture;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                StCapture: begin
                    r_el_data  <= i_mem_data;
                    r_el_valid <= 1'b1;
                    r_state    <= StPresent;
                end
                StPresent: begin
                    if (i_el_ready) begin
                        r_el_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= StIssue;
                            r_mem_rd <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MATRIX_FETCH_CSUM_EN
    logic [DATA_W-1:0] r_csum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_csum <= '0;
        end else if (w_start_ok) begin
            r_csum <= '0;
        end else if (r_state == StCapture) begin
            r_csum <= r_csum + i_mem_data;
        end
    end

    assign o_csum = r_csum;
`endif

    // Address follows the index counter, so it rests at BASE_ADDR between sweeps
    assign o_mem_addr = ADDR_W'(BASE_ADDR + w_idx);
    assign o_mem_rd   = r_mem_rd;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_el_valid = r_el_valid;
    assign o_el_data  = r_el_data;
    assign o_el_row   = w_row;
    assign o_el_col   = w_col;
    assign o_el_last  = r_el_valid & w_last;

endmodule

// File: tb/tb_matrix_fetch.sv
// Bench for matrix_fetch: one instance at RD_LAT=1 and one at RD_LAT=3, each fed by a latency-accurate memory model.
module tb_matrix_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n    [2];
    logic        start    [2];
    logic        el_ready [2];
    logic        busy     [2];
    logic        done     [2];
    logic        mem_rd   [2];
    logic        el_valid [2];
    logic        el_last  [2];
    logic [4:0]  mem_addr [2];
    logic [31:0] mem_data [2];
    logic [31:0] el_data  [2];
    logic [2:0]  el_row   [2];
    logic [2:0]  el_col   [2];
`ifdef MATRIX_FETCH_CSUM_EN
    logic [31:0] csum     [2];
`endif

    logic [31:0] mem_arr [32];
    logic        v_sh [2][4];
    logic [4:0]  a_sh [2][4];

    int n_assert = 0;
    int n_fail   = 0;

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    // Read data appears exactly RD_LAT cycles after the strobe; junk otherwise
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n[u]) begin
                for (int s = 0; s < 4; s++) begin
                    v_sh[u][s] <= 1'b0;
                    a_sh[u][s] <= '0;
                end
            end else begin
                for (int s = 3; s > 0; s--) begin
                    v_sh[u][s] <= v_sh[u][s-1];
                    a_sh[u][s] <= a_sh[u][s-1];
                end
                v_sh[u][0] <= mem_rd[u];
                a_sh[u][0] <= mem_addr[u];
            end
        end
    end

    always_comb begin
        for (int u = 0; u < 2; u++) begin
            mem_data[u] = v_sh[u][lat_of(u)-1] ? mem_arr[a_sh[u][lat_of(u)-1]] : 32'hDEAD;
        end
    end

    matrix_fetch #(.RD_LAT(1)) u_dut_l1 (
        .i_clk      (clk),
        .i_rst_n    (rst_n[0]),
        .i_start    (start[0]),
        .o_busy     (busy[0]),
        .o_done     (done[0]),
        .o_mem_addr (mem_addr[0]),
        .o_mem_rd   (mem_rd[0]),
        .i_mem_data (mem_data[0]),
        .o_el_valid (el_valid[0]),
        .i_el_ready (el_ready[0]),
        .o_el_data  (el_data[0]),
        .o_el_row   (el_row[0]),
        .o_el_col   (el_col[0]),
        .o_el_last  (el_last[0])
`ifdef MATRIX_FETCH_CSUM_EN
        ,
        .o_csum     (csum[0])
`endif
    );

    matrix_fetch #(.RD_LAT(3)) u_dut_l3 (
        .i_clk      (clk),
        .i_rst_n    (rst_n[1]),
        .i_start    (start[1]),
        .o_busy     (busy[1]),
        .o_done     (done[1]),
        .o_mem_addr (mem_addr[1]),
        .o_mem_rd   (mem_rd[1]),
        .i_mem_data (mem_data[1]),
        .o_el_valid (el_valid[1]),
        .i_el_ready (el_ready[1]),
        .o_el_data  (el_data[1]),
        .o_el_row   (el_row[1]),
        .o_el_col   (el_col[1]),
        .o_el_last  (el_last[1])
`ifdef MATRIX_FETCH_CSUM_EN
        ,
        .o_csum     (csum[1])
`endif
    );

    task automatic chk(input int u, input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL u%0d %s: observed 0x%0h expected 0x%0h", u, tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int u);
        chk(u, "rst_busy",     busy[u],     0);
        chk(u, "rst_done",     done[u],     0);
        chk(u, "rst_mem_rd",   mem_rd[u],   0);
        chk(u, "rst_mem_addr", mem_addr[u], 0);
        chk(u, "rst_el_valid", el_valid[u], 0);
        chk(u, "rst_el_data",  el_data[u],  0);
        chk(u, "rst_el_row",   el_row[u],   1);
        chk(u, "rst_el_col",   el_col[u],   1);
        chk(u, "rst_el_last",  el_last[u],  0);
`ifdef MATRIX_FETCH_CSUM_EN
        chk(u, "rst_csum",     csum[u],     0);
`endif
    endtask

    // One sweep checked against the row-major element list; optional stalls, restart, reset
    task automatic sweep(input int u, input bit rand_ready, input int restart_at,
                         input bit start_in_done, input int reset_at);
        int          lat = lat_of(u);
        logic [31:0] exp_q[$];
        logic [31:0] sum = 0;
        int          n = 0;
        int          cyc = 0;
        int          first = -1;
        int          last_hs = -1;
        bit          stall = 1'b0;
        bit          restarted = 1'b0;
        logic [31:0] sd;
        logic [2:0]  sr;
        logic [2:0]  sc;
        logic        sl;
        for (int k = 0; k < 25; k++) begin
            exp_q.push_back(mem_arr[k]);
            sum += mem_arr[k];
        end
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        cyc = 1;
        chk(u, "busy_after_start", busy[u], 1);
`ifdef MATRIX_FETCH_CSUM_EN
        chk(u, "csum_cleared", csum[u], 0);
`endif
        while (n < 25 && cyc < 1000) begin
            if (el_valid[u]) begin
                if (first < 0) begin
                    first = cyc;
                    chk(u, "first_valid_cycle", cyc, lat + 2);
                end
                if (stall) begin
                    chk(u, "stall_data", el_data[u], sd);
                    chk(u, "stall_row",  el_row[u],  sr);
                    chk(u, "stall_col",  el_col[u],  sc);
                    chk(u, "stall_last", el_last[u], sl);
                end
                chk(u, "el_data", el_data[u], exp_q[n]);
                chk(u, "el_row",  el_row[u],  n / 5 + 1);
                chk(u, "el_col",  el_col[u],  n % 5 + 1);
                chk(u, "el_last", el_last[u], (n == 24) ? 1 : 0);
                if (n == reset_at) begin
                    rst_n[u] = 1'b0;
                    #1;
                    check_reset(u);
                    @(negedge clk);
                    rst_n[u] = 1'b1;
                    return;
                end
                el_ready[u] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                stall = !el_ready[u];
                sd = el_data[u];
                sr = el_row[u];
                sc = el_col[u];
                sl = el_last[u];
                if (el_ready[u]) begin
                    if (!rand_ready && last_hs >= 0) chk(u, "elem_period", cyc - last_hs, lat + 2);
                    last_hs = cyc;
                    n++;
                end
            end else begin
                if (stall) chk(u, "valid_dropped", el_valid[u], 1);
                stall = 1'b0;
                chk(u, "busy_mid", busy[u], 1);
                chk(u, "done_mid", done[u], 0);
                if (mem_rd[u]) chk(u, "mem_addr", mem_addr[u], n);
                el_ready[u] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (!restarted && restart_at >= 0 && n >= restart_at) begin
                start[u] = 1'b1;
                restarted = 1'b1;
            end
            @(negedge clk);
            start[u] = 1'b0;
            cyc++;
        end
        chk(u, "sweep_complete", n, 25);
        chk(u, "done_pulse", done[u], 1);
        chk(u, "busy_in_done", busy[u], 1);
        chk(u, "valid_in_done", el_valid[u], 0);
`ifdef MATRIX_FETCH_CSUM_EN
        chk(u, "csum_at_done", csum[u], sum);
`endif
        if (start_in_done) start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        chk(u, "done_cleared", done[u], 0);
        chk(u, "busy_cleared", busy[u], 0);
        chk(u, "row_wrapped",  el_row[u], 1);
        chk(u, "col_wrapped",  el_col[u], 1);
        chk(u, "addr_wrapped", mem_addr[u], 0);
        repeat (lat + 3) begin
            @(negedge clk);
            chk(u, "idle_busy",  busy[u], 0);
            chk(u, "idle_valid", el_valid[u], 0);
            chk(u, "idle_done",  done[u], 0);
`ifdef MATRIX_FETCH_CSUM_EN
            chk(u, "csum_held", csum[u], sum);
`endif
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_n[u]    = 1'b0;
            start[u]    = 1'b0;
            el_ready[u] = 1'b0;
        end
        for (int k = 0; k < 32; k++) mem_arr[k] = 32'h100 + k;
        repeat (2) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);

        // Known data, ready tied high, both latencies
        sweep(0, 1'b0, -1, 1'b0, -1);
        sweep(1, 1'b0, -1, 1'b0, -1);
`ifdef MATRIX_FETCH_CSUM_EN
        chk(0, "csum_known", csum[0], 32'h1A2C);
`endif

        // Random data with random backpressure
        for (int k = 0; k < 32; k++) mem_arr[k] = $urandom;
        sweep(0, 1'b1, -1, 1'b0, -1);
        sweep(1, 1'b1, -1, 1'b0, -1);

        // Extra start pulses mid-sweep and in the DONE cycle
        sweep(0, 1'b1, 6, 1'b1, -1);
        sweep(1, 1'b0, 6, 1'b1, -1);

        // Reset with an element on the stream, then a clean sweep
        for (int u = 0; u < 2; u++) begin
            sweep(u, 1'b1, -1, 1'b0, 11);
            repeat (6) begin
                @(negedge clk);
                chk(u, "post_rst_done", done[u], 0);
                chk(u, "post_rst_busy", busy[u], 0);
            end
            sweep(u, 1'b0, -1, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
